ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 receive FIFO (ps2_keyboard) and pops raw scan-code bytes through the FIFO's ready / nextdata_n handshake.
- Parses set-2 prefix sequences (E0 extended, F0 break) into single key events carrying code, extended, break and repeat flags.
- Tracks the currently held key and counts distinct key presses.
- Its outputs feed the scan-code-to-ASCII and seven-segment display stages.

Parameters:
- COUNT_W, 8: width of press_count.
- TIMEOUT_CYC, 1000000: idle clock cycles allowed inside a prefix state before it is abandoned (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data  in  8  FIFO head byte; valid when ready=1.
- ready  in  1  FIFO non-empty.
- overflow  in  1  FIFO overflow indication.
- nextdata_n  out  1  active-low pop strobe to the FIFO; registered.
- key_valid  out  1  one-cycle pulse; key_* fields are valid.
- key_code  out  8  final scan code of the event (prefixes stripped).
- key_ext  out  1  event was preceded by E0.
- key_break  out  1  event is a release (F0 seen).
- key_repeat  out  1  make event for a code already held (typematic).
- held_valid  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- held_ext  out  1  extended flag of the held key.
- press_count  out  COUNT_W  count of non-repeat make events.
- err  out  1  one-cycle pulse on protocol error or timeout.
- ovf_flag  out  1  sticky; set when overflow is sampled high.

Behaviour:
- Reset (synchronous, active-high), applied on the next clk edge:
  - nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_break=0; key_repeat=0.
  - held_valid=0; held_code=0; held_ext=0; press_count=0; err=0; ovf_flag=0.
  - FSM to S_IDLE; timeout counter cleared.
- Pop handshake, one byte per 2 cycles maximum:
  - Edge k: not popping, and ready=1 sampled → latch data into byte_reg, drive nextdata_n=0 for cycle k+1.
  - Edge k+1: the FIFO advances; the decoder processes byte_reg; nextdata_n returns to 1. No new pop is evaluated at this edge.
  - Edge k+2 onward: ready is re-evaluated.
  - nextdata_n is never low for two consecutive cycles.
- FSM states: S_IDLE, S_EXT, S_BRK, S_EXT_BRK. Transitions on the processed byte b:
  - S_IDLE: b=E0 → S_EXT; b=F0 → S_BRK; otherwise emit make, ext=0, stay S_IDLE.
  - S_EXT: b=F0 → S_EXT_BRK; b=E0 → stay S_EXT (duplicate prefix ignored); otherwise emit make, ext=1, → S_IDLE.
  - S_BRK: b=E0 or F0 → err pulse, → S_IDLE; otherwise emit break, ext=0, → S_IDLE.
  - S_EXT_BRK: b=E0 or F0 → err pulse, → S_IDLE; otherwise emit break, ext=1, → S_IDLE.
  - Any state: b=00 or FF (keyboard error/overrun codes) → err pulse, → S_IDLE, no event.
- Event latency: key_valid and key_* fields update at edge k+1 and are visible in cycle k+2. key_* fields hold until the next event; key_valid is 1 only during that single cycle.
- Make event:
  - key_repeat=1 iff held_valid=1 and {held_ext,held_code} equals the event's {ext,code}.
  - If not a repeat: press_count increments by 1, wrapping from 2^COUNT_W-1 to 0.
  - In all cases held_* is set to the event code, held_valid=1. A new key pressed while another is held replaces it.
- Break event:
  - If it matches held_* → held_valid=0 (held_code and held_ext keep their values).
  - If it does not match → held state unchanged; the event is still emitted.
  - key_repeat=0.
- Timeout:
  - The counter clears on every processed byte and whenever the FSM is in S_IDLE.
  - In any prefix state the counter increments each cycle. On reaching TIMEOUT_CYC-1: err pulse, → S_IDLE, counter cleared.
- Overflow: ovf_flag is set in the cycle after overflow=1 is sampled and stays set until reset. Overflow does not block popping.
- Reset asserted while nextdata_n=0: nextdata_n=1 after that edge. The FIFO consumes the byte at that same edge, so the byte is lost with no event and no err.
- Simultaneous timeout expiry and byte processing: the byte takes priority and the timeout is discarded.

Test Plan:
- Stream 1C, F0, 1C, spaced 10 cycles apart → make event (code 1C, ext 0, break 0, repeat 0) then break event (code 1C, break 1); press_count=1; held_valid goes 1 then 0; nextdata_n low exactly 3 single cycles.
- E0 75, then E0 F0 75 → make (75, ext 1) then break (75, ext 1, break 1); exactly 2 key_valid pulses.
- 1C, 1C, 1C with no break → 3 make events with key_repeat 0, 1, 1; press_count=1.
- COUNT_W=4, 17 alternating make/break pairs with distinct codes → press_count=1 after wrap; no err.
- TIMEOUT_CYC=16, send F0 then stall → err pulses in cycle 16 after the F0 is processed; next byte 1C → make event, not break.
- Send 00, then E0 F0 F0 → err pulse for 00 and err pulse for the second F0; no key events. Pulse overflow=1 → ovf_flag=1 until reset.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Pops raw set-2 scan-code bytes from the PS/2 receive FIFO and turns the
// E0 (extended) / F0 (break) prefix sequences into single key events. It
// also tracks the held key, counts distinct presses and flags errors.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   data, ready   FIFO head byte and non-empty flag
//   overflow      FIFO overflow indication (captured into sticky ovf_flag)
//   nextdata_n    registered active-low pop strobe to the FIFO
//   key_valid     one-cycle pulse qualifying key_code/ext/break/repeat
//   held_*        currently held key
//   press_count   number of non-repeat make events (wraps)
//   err           one-cycle pulse on protocol error or prefix timeout
//   ovf_flag      sticky overflow flag
module ps2_key_decoder #(
  parameter int COUNT_W     = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         data,
  input  logic               ready,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic               key_repeat,
  output logic               held_valid,
  output logic [7:0]         held_code,
  output logic               held_ext,
  output logic [COUNT_W-1:0] press_count,
  output logic               err,
  output logic               ovf_flag
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t             state_q, state_d;
  logic               pop_q, pop_d;
  logic [7:0]         byte_q, byte_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               key_valid_q, key_valid_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_break_q, key_break_d;
  logic               key_repeat_q, key_repeat_d;
  logic               held_valid_q, held_valid_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_ext_q, held_ext_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;

  logic               ev_valid, ev_ext, ev_brk, ev_match;
  logic [TW-1:0]      tmo_inc;

  always_comb begin
    state_d      = state_q;
    pop_d        = 1'b0;
    byte_d       = byte_q;
    tmo_d        = tmo_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_repeat_d = key_repeat_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    count_d      = count_q;
    err_d        = 1'b0;
    ovf_d        = ovf_q | overflow;
    ev_valid     = 1'b0;
    ev_ext       = 1'b0;
    ev_brk       = 1'b0;
    ev_match     = 1'b0;
    tmo_inc      = tmo_q + 1'b1;

    if (pop_q) begin
      // The pop cycle doubles as the processing cycle for the latched byte;
      // no new pop is started here, which caps throughput at 1 byte / 2 cycles.
      tmo_d = '0;
      if (byte_q == 8'h00 || byte_q == 8'hFF) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_q == 8'hE0)      state_d = S_EXT;
            else if (byte_q == 8'hF0) state_d = S_BRK;
            else                      ev_valid = 1'b1;
          end
          S_EXT: begin
            if (byte_q == 8'hF0) state_d = S_EXT_BRK;
            else if (byte_q != 8'hE0) begin
              ev_valid = 1'b1;
              ev_ext   = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_d = S_IDLE;
            if (byte_q == 8'hE0 || byte_q == 8'hF0) begin
              err_d = 1'b1;
            end else begin
              ev_valid = 1'b1;
              ev_brk   = 1'b1;
              ev_ext   = (state_q == S_EXT_BRK);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else begin
      if (ready) begin
        pop_d  = 1'b1;
        byte_d = data;
      end
      // Timeout only runs when no byte is processed, so a byte arriving on
      // the expiry cycle wins.
      if (state_q == S_IDLE) begin
        tmo_d = '0;
      end else if (tmo_inc == TMO_LIM) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_inc;
      end
    end

    if (ev_valid) begin
      ev_match     = held_valid_q && (held_ext_q == ev_ext) && (held_code_q == byte_q);
      key_valid_d  = 1'b1;
      key_code_d   = byte_q;
      key_ext_d    = ev_ext;
      key_break_d  = ev_brk;
      key_repeat_d = 1'b0;
      if (!ev_brk) begin
        key_repeat_d = ev_match;
        if (!ev_match) count_d = count_q + 1'b1;
        held_valid_d = 1'b1;
        held_code_d  = byte_q;
        held_ext_d   = ev_ext;
      end else if (ev_match) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pop_q        <= 1'b0;
      byte_q       <= '0;
      tmo_q        <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop_d;
      byte_q       <= byte_d;
      tmo_q        <= tmo_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_repeat_q <= key_repeat_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      count_q      <= count_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign nextdata_n  = ~pop_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_break   = key_break_q;
  assign key_repeat  = key_repeat_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign press_count = count_q;
  assign err         = err_q;
  assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: a queue-based FIFO feeds the decoder, a
// transaction-level key model predicts every output each cycle, and directed
// scenarios pin the model with hand-computed literal expectations.
module tb_ps2_key_decoder;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data = '0;
  logic          ready = 1'b0;
  logic          overflow = 1'b0;
  logic          nextdata_n, key_valid, key_ext, key_break, key_repeat;
  logic          held_valid, held_ext, err, ovf_flag;
  logic [7:0]    key_code, held_code;
  logic [CW-1:0] press_count;

  ps2_key_decoder #(.COUNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
    .held_valid(held_valid), .held_code(held_code), .held_ext(held_ext),
    .press_count(press_count), .err(err), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ev_t;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] fifo[$];
  ev_t  evq[$];
  int   kv_cnt = 0, err_cnt = 0, ndn_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: pending pop, prefix flags, held key, counters, last event.
  logic       armed = 1'b0;
  logic       m_pend, m_ext, m_brk, m_hv, m_he, m_ovf;
  logic [7:0] m_byte, m_hc;
  int         m_age, m_cnt;
  logic       e_kv, e_err, e_ext, e_brk, e_rep;
  logic [7:0] e_code;
  logic       s_rst, s_rdy, s_ovf, s_ndn;
  logic [7:0] s_dat;

  task automatic m_event(input logic [7:0] c, input logic ex, input logic br);
    logic match;
    match  = m_hv && (m_hc == c) && (m_he == ex);
    e_kv   = 1'b1; e_code = c; e_ext = ex; e_brk = br; e_rep = 1'b0;
    if (!br) begin
      e_rep = match;
      if (!match) m_cnt = (m_cnt + 1) % (1 << CW);
      m_hv = 1'b1; m_hc = c; m_he = ex;
    end else if (match) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic m_proc(input logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin
      e_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin
        e_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) m_ext = 1'b1;
      else m_brk = 1'b1;
    end else begin
      m_event(b, m_ext, m_brk);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    s_rst = reset; s_rdy = ready; s_dat = data; s_ovf = overflow; s_ndn = nextdata_n;
    #1;
    // FIFO environment: it consumes the head byte whenever it saw the strobe.
    if (!s_ndn && fifo.size() > 0) fifo.delete(0);
    ready = (fifo.size() > 0);
    data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    if (key_valid) begin
      kv_cnt++;
      evq.push_back('{key_code, key_ext, key_break, key_repeat});
    end
    if (err) err_cnt++;
    if (!nextdata_n) ndn_cnt++;

    e_kv = 1'b0; e_err = 1'b0;
    if (s_rst) begin
      armed = 1'b1;
      m_pend = 0; m_ext = 0; m_brk = 0; m_hv = 0; m_he = 0; m_ovf = 0;
      m_byte = '0; m_hc = '0; m_age = 0; m_cnt = 0;
      e_ext = 0; e_brk = 0; e_rep = 0; e_code = '0;
    end else if (armed) begin
      if (m_pend) begin
        m_proc(m_byte);
        m_pend = 1'b0;
        m_age  = 0;
      end else begin
        if (s_rdy) begin
          m_pend = 1'b1; m_byte = s_dat;
        end
        if (m_ext || m_brk) begin
          m_age++;
          if (m_age == TO - 1) begin
            e_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0; m_age = 0;
          end
        end else m_age = 0;
      end
      if (s_ovf) m_ovf = 1'b1;
    end
    if (armed) begin
      chk("nextdata_n", nextdata_n, !m_pend);
      chk("key_valid", key_valid, e_kv);
      chk("key_code", key_code, e_code);
      chk("key_ext", key_ext, e_ext);
      chk("key_break", key_break, e_brk);
      chk("key_repeat", key_repeat, e_rep);
      chk("held_valid", held_valid, m_hv);
      chk("held_code", held_code, m_hc);
      chk("held_ext", held_ext, m_he);
      chk("press_count", press_count, m_cnt);
      chk("err", err, e_err);
      chk("ovf_flag", ovf_flag, m_ovf);
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo.push_back(b);
    ready = 1'b1;
    data  = fifo[0];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    kv_cnt = 0; err_cnt = 0; ndn_cnt = 0;
    evq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    clear_counts();
  endtask

  initial begin
    int n;
    // Reset state
    idle(2);
    reset = 1'b0;
    chk("rst_ndn", nextdata_n, 1);
    chk("rst_kv", key_valid, 0);
    chk("rst_count", press_count, 0);
    chk("rst_held", held_valid, 0);
    clear_counts();

    // 1C, F0, 1C spaced apart: make then break
    push(8'h1C); idle(4);
    chk("t1_held_mid", held_valid, 1);
    idle(4);
    push(8'hF0); idle(8);
    push(8'h1C); idle(8);
    chk("t1_kv", kv_cnt, 2);
    chk("t1_ndn_low", ndn_cnt, 3);
    chk("t1_count", press_count, 1);
    chk("t1_held_end", held_valid, 0);
    if (evq.size() == 2) begin
      chk("t1_ev0", evq[0], {8'h1C, 1'b0, 1'b0, 1'b0});
      chk("t1_ev1", evq[1], {8'h1C, 1'b0, 1'b1, 1'b0});
    end

    // Extended make then extended break, back to back
    clear_counts();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    idle(14);
    chk("t2_kv", kv_cnt, 2);
    chk("t2_count", press_count, 2);
    if (evq.size() == 2) begin
      chk("t2_ev0", evq[0], {8'h75, 1'b1, 1'b0, 1'b0});
      chk("t2_ev1", evq[1], {8'h75, 1'b1, 1'b1, 1'b0});
    end

    // Typematic repeat
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C);
    idle(10);
    chk("t3_kv", kv_cnt, 3);
    chk("t3_count", press_count, 1);
    if (evq.size() == 3) begin
      chk("t3_rep0", evq[0].rep, 0);
      chk("t3_rep1", evq[1].rep, 1);
      chk("t3_rep2", evq[2].rep, 1);
    end

    // Counter wrap: 17 distinct presses into a 4-bit count
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(8'(8'h10 + i)); push(8'hF0); push(8'(8'h10 + i));
      idle(6);
    end
    chk("t4_count", press_count, 1);
    chk("t4_err", err_cnt, 0);
    chk("t4_kv", kv_cnt, 34);

    // Timeout after F0, then 1C is a make
    do_reset();
    push(8'hF0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (err) break;
    end
    chk("t5_tmo_edge", n, 17);
    push(8'h1C); idle(6);
    chk("t5_kv", kv_cnt, 1);
    if (evq.size() == 1) chk("t5_ev", evq[0], {8'h1C, 1'b0, 1'b0, 1'b0});

    // Error codes and double break prefix; overflow sticky flag
    do_reset();
    push(8'h00); push(8'hE0); push(8'hF0); push(8'hF0);
    idle(10);
    chk("t6_err", err_cnt, 2);
    chk("t6_kv", kv_cnt, 0);
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    idle(5);
    chk("t6_ovf", ovf_flag, 1);
    do_reset();
    chk("t6_ovf_rst", ovf_flag, 0);

    // Reset during the pop cycle loses the byte silently
    push(8'h2A);
    @(negedge clk);
    chk("t7_ndn_low", nextdata_n, 0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    clear_counts();
    idle(6);
    chk("t7_kv", kv_cnt, 0);
    chk("t7_err", err_cnt, 0);
    chk("t7_fifo", fifo.size(), 0);
    chk("t7_count", press_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
